// File: rtl/alu_serial_seq.sv
// Bit-serial sequencer driving one alu_1bit slice LSB-first; assembles a
// WIDTH-bit result plus zero/carry/overflow flags from the slice outputs.
module alu_serial_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [2:0]       op_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             cout,
  output logic             ovf,
  output logic             sl_a,
  output logic             sl_b,
  output logic [2:0]       sl_op,
  output logic             sl_cin,
  output logic             sl_lessi,
  input  logic             sl_r,
  input  logic             sl_cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] BIT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] a_sh_r, b_sh_r, acc_r;
  logic [2:0]       op_r;
  logic             slt_r;
  logic             carry_r;
  logic [CW-1:0]    bit_r;
  logic             accept_s, last_s;
  logic [3:0]       dec_s;
  logic [WIDTH-1:0] acc_next_s, res_next_s;
  logic             cout_next_s, ovf_next_s, msb_ovf_s;

  // slt runs on the slice as a subtract; unused codes collapse to and
  function automatic logic [3:0] decode_op(input logic [2:0] op);
    logic [3:0] d;
    case (op)
      3'b000:  d = 4'b0000;
      3'b001:  d = 4'b0001;
      3'b010:  d = 4'b0010;
      3'b110:  d = 4'b0110;
      3'b111:  d = 4'b1110;
      default: d = 4'b0000;
    endcase
    return d;
  endfunction

  assign dec_s    = decode_op(op_in);
  assign accept_s = (state_r == IDLE) && start;
  assign last_s   = (state_r == RUN) && (bit_r == LAST_BIT);

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = RUN;
        else       state_s = IDLE;
      end
      RUN: begin
        if (bit_r == LAST_BIT) state_s = DONE;
        else                   state_s = RUN;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // final result and flags, valid on the cycle the MSB is processed
  always_comb begin
    acc_next_s  = {sl_r, acc_r[WIDTH-1:1]};
    msb_ovf_s   = carry_r ^ sl_cout;
    res_next_s  = acc_next_s;
    cout_next_s = 1'b0;
    ovf_next_s  = 1'b0;
    if (slt_r) begin
      res_next_s = {{(WIDTH-1){1'b0}}, sl_r ^ msb_ovf_s};
    end else if (op_r[1]) begin
      cout_next_s = sl_cout;
      ovf_next_s  = msb_ovf_s;
    end else begin
      res_next_s = acc_next_s;
    end
  end

  // operand shift registers, carry chain and bit counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh_r  <= '0;
      b_sh_r  <= '0;
      acc_r   <= '0;
      op_r    <= 3'b000;
      slt_r   <= 1'b0;
      carry_r <= 1'b0;
      bit_r   <= '0;
    end else if (accept_s) begin
      a_sh_r  <= a_in;
      b_sh_r  <= b_in;
      acc_r   <= '0;
      op_r    <= dec_s[2:0];
      slt_r   <= dec_s[3];
      carry_r <= dec_s[2];
      bit_r   <= '0;
    end else if (state_r == RUN) begin
      a_sh_r  <= a_sh_r >> 1;
      b_sh_r  <= b_sh_r >> 1;
      acc_r   <= acc_next_s;
      carry_r <= sl_cout;
      bit_r   <= bit_r + BIT_ONE;
    end
  end

  // registered status and result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      zero   <= 1'b0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      done <= last_s;
      if (accept_s)              busy <= 1'b1;
      else if (state_r == DONE)  busy <= 1'b0;
      if (last_s) begin
        result <= res_next_s;
        zero   <= (res_next_s == '0);
        cout   <= cout_next_s;
        ovf    <= ovf_next_s;
      end
    end
  end

  assign sl_a     = (state_r == RUN) ? a_sh_r[0] : 1'b0;
  assign sl_b     = (state_r == RUN) ? b_sh_r[0] : 1'b0;
  assign sl_op    = (state_r == RUN) ? op_r      : 3'b000;
  assign sl_cin   = (state_r == RUN) ? carry_r   : 1'b0;
  assign sl_lessi = 1'b0;

endmodule
